// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: ALU/RF requester handshakes plus the async-FIFO write side.
interface fifo_wr_arbiter_if #(parameter int DATA_WIDTH = 8);
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_vld;
  logic                    alu_rdy;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_vld;
  logic                    rf_rdy;
  logic                    fifo_full;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    w_inc;
  logic                    busy;
  logic [7:0]              wr_cnt;
  modport master(
    output alu_out, alu_vld, rf_rd_data, rf_vld, fifo_full,
    input  alu_rdy, rf_rdy, wr_data, w_inc, busy, wr_cnt
  );
  modport slave(
    input  alu_out, alu_vld, rf_rd_data, rf_vld, fifo_full,
    output alu_rdy, rf_rdy, wr_data, w_inc, busy, wr_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: arbitrates ALU/RF results into byte writes on an async FIFO.
// FIFO_ARB_RR_EN selects round-robin tie-break; default is fixed ALU priority.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;
  state_t                  state, next;
  logic [2*DATA_WIDTH-1:0] hold;
  logic                    is_alu;
  logic                    prefer_alu;
  logic                    grant_alu;
  logic                    grant_rf;
  logic                    w_inc;
  logic [7:0]              wr_cnt;
`ifdef FIFO_ARB_RR_EN
  logic last_alu;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_alu <= 1'b1;
    else if (grant_alu || grant_rf) last_alu <= grant_alu;
  assign prefer_alu = !last_alu;
`else
  assign prefer_alu = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? ((grant_alu || grant_rf) ? WR_LO : IDLE)
         : !w_inc ? state
         : (state == WR_LO && is_alu) ? WR_HI : IDLE;
  // rst_n gates the grants so RDY stays low while reset is asserted
  always_comb begin
    grant_alu = rst_n && state == IDLE && bus.alu_vld && (prefer_alu || !bus.rf_vld);
    grant_rf  = rst_n && state == IDLE && bus.rf_vld && !grant_alu;
    w_inc     = state != IDLE && !bus.fifo_full;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold   <= '0;
      is_alu <= 1'b0;
      wr_cnt <= '0;
    end else begin
      if (grant_alu || grant_rf) begin
        hold   <= grant_alu ? bus.alu_out : {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
        is_alu <= grant_alu;
      end
      if (w_inc) wr_cnt <= wr_cnt + 8'd1;
    end
  assign bus.alu_rdy = grant_alu;
  assign bus.rf_rdy  = grant_rf;
  assign bus.w_inc   = w_inc;
  assign bus.busy    = state != IDLE;
  assign bus.wr_cnt  = wr_cnt;
  assign bus.wr_data = state == WR_HI ? hold[2*DATA_WIDTH-1:DATA_WIDTH] : hold[DATA_WIDTH-1:0];
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, FIFO write-data width in bits; the ALU operand width is 2*DATA_WIDTH.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: CLK  in  1  clock; all state is updated on its rising edge.
REQ-004 Port: RST  in  1  reset; asynchronous, active-low.
REQ-005 Port: ALU_OUT  in  2*DATA_WIDTH  ALU result to be sent.
REQ-006 Port: ALU_VLD  in  1  ALU result is pending; held high until ALU_RDY.
REQ-007 Port: ALU_RDY  out  1  one-cycle accept pulse to the ALU requester.
REQ-008 Port: RF_RD_DATA  in  DATA_WIDTH  register-file read data to be sent.
REQ-009 Port: RF_VLD  in  1  RF data is pending; held high until RF_RDY.
REQ-010 Port: RF_RDY  out  1  one-cycle accept pulse to the RF requester.
REQ-011 Port: FIFO_FULL  in  1  FULL flag from the async FIFO write side.
REQ-012 Port: WR_DATA  out  DATA_WIDTH  FIFO write data.
REQ-013 Port: W_INC  out  1  FIFO write strobe; one byte is written per high cycle.
REQ-014 Port: BUSY  out  1  high whenever the FSM is not IDLE.
REQ-015 Port: WR_CNT  out  8  count of bytes written to the FIFO.

Function
REQ-016 The FSM SHALL have three states: IDLE, WR_LO and WR_HI.
REQ-017 Accept happens only in IDLE: on accept, the granted RDY is high for exactly that cycle and the data is captured into the holding register.
- RF grant: next state WR_LO, single byte.
- ALU grant: next state WR_LO, then WR_HI.
REQ-018 With exactly one VLD high in IDLE, that requester SHALL be granted.
REQ-019 With both VLD high in IDLE, the grant SHALL follow the arbitration rule in REQ-031/REQ-032.
REQ-020 Write strobe: W_INC = (state is WR_LO or WR_HI) AND NOT FIFO_FULL. This is combinational, so no byte is ever written while FULL is high.
REQ-021 WR_DATA SHALL be the registered holding-register output:
- RF byte, or ALU bits [DATA_WIDTH-1:0], in WR_LO;
- ALU bits [2*DATA_WIDTH-1:DATA_WIDTH] in WR_HI.
REQ-022 FIFO_FULL high in a WR state: the state and WR_DATA SHALL be held until FULL falls; nothing is dropped or duplicated.
REQ-023 WR_LO exits on W_INC: to WR_HI for an ALU transfer, to IDLE for an RF transfer. WR_HI exits to IDLE on W_INC.
REQ-024 Latency: W_INC SHALL be high at the earliest in the cycle after accept. The next accept SHALL be possible in the cycle after the last W_INC.
REQ-025 RDY SHALL never be asserted outside IDLE, and never to both requesters in the same cycle.
REQ-026 WR_CNT SHALL increment by 1 on every W_INC cycle and wrap 255 -> 0.
REQ-027 BUSY SHALL be high in WR_LO and WR_HI, and low in IDLE.

Reset
REQ-028 RST low SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- force W_INC, ALU_RDY and RF_RDY low, BUSY 0, WR_CNT 0, WR_DATA 0;
- clear the holding register;
- reset the round-robin pointer to "ALU last served".
REQ-029 A reset during WR_LO or WR_HI SHALL discard the pending byte(s); after release, no partial-transfer write follows.
REQ-030 After RST rises, the first accept SHALL occur no earlier than the first rising CLK edge.

Configuration
REQ-031 With macro FIFO_ARB_RR_EN defined:
- simultaneous requests SHALL be granted round-robin;
- a 1-bit pointer records the last-served requester, and the other requester wins a tie;
- the pointer updates on every accept.
REQ-032 Without FIFO_ARB_RR_EN: fixed priority, ALU over RF; no pointer is implemented.

Verification
REQ-033 RF_VLD=1, RF_RD_DATA=0x5A, FIFO_FULL=0 -> RF_RDY pulses one cycle; next cycle W_INC=1 with WR_DATA=0x5A; WR_CNT=1; return to IDLE.
REQ-034 ALU_VLD=1, ALU_OUT=0x1234 -> W_INC on two consecutive cycles with WR_DATA 0x34 then 0x12; WR_CNT=2.
REQ-035 FIFO_FULL=1 during WR_LO of ALU_OUT=0xABCD for 5 cycles -> W_INC=0 and WR_DATA=0xCD held; after FULL falls: 0xCD then 0xAB, no loss or duplication.
REQ-036 ALU_VLD and RF_VLD both held high with fresh data, macro defined -> grants alternate RF, ALU, RF, ALU starting with RF after reset. Macro undefined -> ALU is granted every time.
REQ-037 RST pulsed low mid-WR_HI of ALU_OUT=0x0F0F -> W_INC=0, BUSY=0, WR_CNT=0 immediately; no 0x0F written after release.
REQ-038 256 RF bytes written -> WR_CNT wraps to 0.
